// File: rtl/bram_fifo_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the BRAM FIFO UART drain engine.
//   tx_state_t      : drain FSM states
//   UART_FRAME_BITS : start + 8 data + stop
//   UART_DATA_BITS  : data bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/bram_fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// bram_fifo_uart_tx_if
// Read-port (B side) handshake between the BRAM FIFO and its consumer.
//   data_out_b : FIFO read data, valid the cycle after a pop
//   empty      : FIFO empty flag
//   r_en_b     : one-cycle pop strobe
// Modports:
//   master : the consumer, which initiates pops
//   slave  : the FIFO, which answers them
// -----------------------------------------------------------------------------
interface bram_fifo_uart_tx_if #(
    parameter int DATAW = 32
);
    logic [DATAW-1:0] data_out_b;
    logic             empty;
    logic             r_en_b;

    modport master (
        input  data_out_b,
        input  empty,
        output r_en_b
    );

    modport slave (
        output data_out_b,
        output empty,
        input  r_en_b
    );
endinterface

// File: rtl/bram_fifo_uart_tx_baud_timer.sv
// -----------------------------------------------------------------------------
// uart_baud_timer
// Free-running bit-period counter, 0..CLK_PER_BIT-1.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the period (asserted on every FSM state change)
//   tick : high on the last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int              CNT_W    = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == CNT_LAST);
endmodule

// File: rtl/bram_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// bram_fifo_uart_tx
// Drains words from the BRAM FIFO read port and sends each word LSB byte
// first as 8N1 UART frames, with no gap between the bytes of one word.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   fifo  : FIFO read port (data_out_b, empty, r_en_b)
//   txd   : registered serial output, idle high
//   busy  : high from the pop cycle through the last stop-bit cycle
// -----------------------------------------------------------------------------
module bram_fifo_uart_tx
    import uart_pkg::*;
#(
    parameter  int DATAW       = 32,
    parameter  int CLK_PER_BIT = 868,
    localparam int NBYTES      = DATAW / 8
) (
    input  logic                clk,
    input  logic                rst,
    bram_fifo_uart_tx_if.master fifo,
    output logic                txd,
    output logic                busy
);
    localparam int               BYTE_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t         r_state, w_state_next;
    logic [DATAW-1:0]  r_word;
    logic [BYTE_W-1:0] r_byte_idx, w_byte_idx_next;
    logic [2:0]        r_bit_idx, w_bit_idx_next;
    logic              r_txd, w_txd_next;
    logic              w_tick, w_clr, w_pop, w_latch;
    logic [7:0]        w_byte;

    uart_baud_timer #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_baud_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // Pop only from IDLE, so a pop can never land while a word is in flight.
    assign w_pop       = (r_state == IDLE) && !fifo.empty && !rst;
    assign fifo.r_en_b = w_pop;
    assign busy        = ((r_state != IDLE) && !rst) || w_pop;
    assign txd         = r_txd;

    // Any state change restarts the bit period.
    assign w_clr = (w_state_next != r_state);

    // Byte selected by the upcoming byte index, so txd can be registered.
    assign w_byte = 8'(r_word >> {w_byte_idx_next, 3'b000});

    always_comb begin
        w_state_next    = r_state;
        w_byte_idx_next = r_byte_idx;
        w_bit_idx_next  = r_bit_idx;
        w_latch         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_latch         = 1'b1;
                w_byte_idx_next = '0;
                w_state_next    = START;
            end
            START: begin
                if (w_tick) begin
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_byte_idx != LAST_BYTE) begin
                        w_byte_idx_next = r_byte_idx + 1'b1;
                        w_state_next    = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line level for the state the FSM is about to enter.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = w_byte[w_bit_idx_next];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_byte_idx <= w_byte_idx_next;
            r_bit_idx  <= w_bit_idx_next;
            r_txd      <= w_txd_next;
            if (w_latch) begin
                r_word <= fifo.data_out_b;
            end
        end
    end
endmodule
